// File: rtl/hd_drv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hd_drv_pkg
// Purpose  : Shared widths and FSM state encoding for the HD kernel driver.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package hd_drv_pkg;

  localparam int KX_W  = 16;  // kernel input word width (A in low byte, B in high byte)
  localparam int KY_W  = 8;   // kernel output width
  localparam int CNT_W = 4;   // evaluation window counter width

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_B = 2'd1,
    EVAL   = 2'd2,
    OUT    = 2'd3
  } drv_state_e;

endpackage
`default_nettype wire

// File: rtl/hd_kernel_driver_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hd_kernel_driver_if
// Purpose  : Operand byte stream and result stream of the HD kernel driver.
//            master = harness side, slave = driver side.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface hd_kernel_driver_if #(
  parameter int TAG_W = 4
);
  import hd_drv_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic             res_valid;
  logic             res_ready;
  logic [KY_W-1:0]  res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_par;

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_tag, res_par
  );

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_tag, res_par
  );

endinterface
`default_nettype wire

// File: rtl/hd_drv_eval_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hd_drv_eval_timer
// Purpose  : Loadable down-counter with zero flag; times the kernel
//            evaluation window. Stops at zero rather than wrapping.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module hd_drv_eval_timer
  import hd_drv_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  input  wire logic             dec_i,
  output logic                  zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, otherwise count down and hold at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/hd_kernel_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : hd_kernel_driver
// Purpose  : Pairs two operand bytes into a 16-bit kernel input word, holds
//            it for EVAL_CYCLES cycles, captures the 8-bit kernel result and
//            returns it with a wrapping tag.
//            Optional macro HD_DRV_PARITY_EN: registers even parity of the
//            captured result on res_par (tied 0 when undefined).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module hd_kernel_driver
  import hd_drv_pkg::*;
#(
  parameter int EVAL_CYCLES = 1,
  parameter int TAG_W       = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  hd_kernel_driver_if.slave    bus,
  output logic [KX_W-1:0]      kx_o,
  input  wire logic [KY_W-1:0] ky_i
);

  if ((EVAL_CYCLES < 1) || (EVAL_CYCLES > 15)) begin : g_eval_range_check
    $error("hd_kernel_driver: EVAL_CYCLES must be in 1..15");
  end

  drv_state_e       state_q;
  drv_state_e       state_d;

  logic [KX_W-1:0]  kx_q;
  logic [KY_W-1:0]  res_data_q;
  logic             res_valid_q;
  logic [TAG_W-1:0] res_tag_q;

  logic             in_ready_w;
  logic             in_hs_w;
  logic             timer_load_w;
  logic             timer_dec_w;
  logic             timer_zero_w;
  logic             capture_w;
  logic             consume_w;

  assign in_hs_w = bus.in_valid & in_ready_w;

  hd_drv_eval_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load_w),
    .load_val_i (CNT_W'(EVAL_CYCLES - 1)),
    .dec_i      (timer_dec_w),
    .zero_o     (timer_zero_w)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: A byte, B byte, evaluation window, then hold result until taken.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs_w)       state_d = WAIT_B;
      WAIT_B:  if (in_hs_w)       state_d = EVAL;
      EVAL:    if (timer_zero_w)  state_d = OUT;
      OUT:     if (bus.res_ready) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // State-decoded controls; in_ready is held low for the whole reset.
  always_comb begin
    in_ready_w   = 1'b0;
    timer_load_w = 1'b0;
    timer_dec_w  = 1'b0;
    capture_w    = 1'b0;
    consume_w    = 1'b0;
    case (state_q)
      IDLE:    in_ready_w = ~rst;
      WAIT_B: begin
        in_ready_w   = ~rst;
        timer_load_w = in_hs_w;
      end
      EVAL: begin
        timer_dec_w = 1'b1;
        capture_w   = timer_zero_w;
      end
      OUT:     consume_w = bus.res_ready;
      default: in_ready_w = 1'b0;
    endcase
  end

  // Operand word: only byte handshakes touch it, so it stays stable on the kernel.
  always_ff @(posedge clk) begin
    if (rst) begin
      kx_q <= '0;
    end else if (in_hs_w) begin
      if (state_q == IDLE) begin
        kx_q[7:0] <= bus.in_data;
      end else begin
        kx_q[15:8] <= bus.in_data;
      end
    end
  end

  // Result capture, valid flag and sequence tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_q  <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
    end else if (capture_w) begin
      res_data_q  <= ky_i;
      res_valid_q <= 1'b1;
    end else if (consume_w) begin
      res_valid_q <= 1'b0;
      res_tag_q   <= res_tag_q + 1'b1;
    end
  end

`ifdef HD_DRV_PARITY_EN
  logic res_par_q;

  // Parity is captured together with the result byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_par_q <= 1'b0;
    end else if (capture_w) begin
      res_par_q <= ^ky_i;
    end
  end

  assign bus.res_par = res_par_q;
`else
  assign bus.res_par = 1'b0;
`endif

  assign kx_o          = kx_q;
  assign bus.in_ready  = in_ready_w;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;

endmodule
`default_nettype wire

// File: tb/tb_hd_kernel_driver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_hd_kernel_driver
// Purpose  : Self-checking bench for hd_kernel_driver. Two instances
//            (EVAL_CYCLES = 1 and 15) run against a transaction-level model
//            with an XOR kernel stub on each.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_hd_kernel_driver;

  localparam int TAG_W = 4;
  localparam int EV0   = 1;
  localparam int EV1   = 15;
`ifdef HD_DRV_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        tb_rst [2];
  logic        tb_iv  [2];
  logic        tb_rr  [2];
  logic [7:0]  tb_id  [2];
  logic [15:0] kx     [2];
  logic [7:0]  ky     [2];

  hd_kernel_driver_if #(.TAG_W(TAG_W)) if0 ();
  hd_kernel_driver_if #(.TAG_W(TAG_W)) if1 ();

  assign if0.in_valid  = tb_iv[0];
  assign if0.in_data   = tb_id[0];
  assign if0.res_ready = tb_rr[0];
  assign if1.in_valid  = tb_iv[1];
  assign if1.in_data   = tb_id[1];
  assign if1.res_ready = tb_rr[1];

  // Kernel stub: y = A ^ B.
  assign ky[0] = kx[0][7:0] ^ kx[0][15:8];
  assign ky[1] = kx[1][7:0] ^ kx[1][15:8];

  hd_kernel_driver #(.EVAL_CYCLES(EV0), .TAG_W(TAG_W)) u_dut0 (
    .clk  (clk),
    .rst  (tb_rst[0]),
    .bus  (if0),
    .kx_o (kx[0]),
    .ky_i (ky[0])
  );

  hd_kernel_driver #(.EVAL_CYCLES(EV1), .TAG_W(TAG_W)) u_dut1 (
    .clk  (clk),
    .rst  (tb_rst[1]),
    .bus  (if1),
    .kx_o (kx[1]),
    .ky_i (ky[1])
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Transaction-level model state per instance.
  int               m_nb   [2];  // operand bytes collected (0..2)
  int               m_age  [2];  // cycles elapsed since B accepted
  logic [15:0]      m_kx   [2];
  logic             m_rv   [2];
  logic [7:0]       m_rd   [2];
  logic [TAG_W-1:0] m_tag  [2];
  logic             m_par  [2];
  logic             m_init [2];

  function automatic logic o_ir(int i);
    return (i == 0) ? if0.in_ready : if1.in_ready;
  endfunction
  function automatic logic o_rv(int i);
    return (i == 0) ? if0.res_valid : if1.res_valid;
  endfunction
  function automatic logic [7:0] o_rd(int i);
    return (i == 0) ? if0.res_data : if1.res_data;
  endfunction
  function automatic logic [TAG_W-1:0] o_tag(int i);
    return (i == 0) ? if0.res_tag : if1.res_tag;
  endfunction
  function automatic logic o_par(int i);
    return (i == 0) ? if0.res_par : if1.res_par;
  endfunction

  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s u%0d: got %0h expected %0h (t=%0t)", nm, i, act, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_edge(int i);
    int         ev;
    logic [7:0] y;
    ev = (i == 0) ? EV0 : EV1;
    if (tb_rst[i]) begin
      m_nb[i] = 0; m_age[i] = 0; m_kx[i] = '0; m_rv[i] = 1'b0;
      m_rd[i] = '0; m_tag[i] = '0; m_par[i] = 1'b0; m_init[i] = 1'b1;
    end else if (m_rv[i]) begin
      if (tb_rr[i]) begin
        m_rv[i]  = 1'b0;
        m_tag[i] = m_tag[i] + 1'b1;
        m_nb[i]  = 0;
      end
    end else if (m_nb[i] == 2) begin
      m_age[i] = m_age[i] + 1;
      if (m_age[i] == ev) begin
        y        = m_kx[i][7:0] ^ m_kx[i][15:8];
        m_rd[i]  = y;
        m_par[i] = PAR_EN & (^y);
        m_rv[i]  = 1'b1;
      end
    end else if (tb_iv[i]) begin
      if (m_nb[i] == 0) begin
        m_kx[i][7:0] = tb_id[i];
      end else begin
        m_kx[i][15:8] = tb_id[i];
        m_age[i]      = 0;
      end
      m_nb[i] = m_nb[i] + 1;
    end
  endtask

  task automatic compare(int i);
    logic exp_ir;
    exp_ir = !tb_rst[i] && !m_rv[i] && (m_nb[i] < 2);
    chk("in_ready", i, 32'(o_ir(i)), 32'(exp_ir));
    chk("kx_o", i, 32'(kx[i]), 32'(m_kx[i]));
    chk("res_valid", i, 32'(o_rv(i)), 32'(m_rv[i]));
    chk("res_tag", i, 32'(o_tag(i)), 32'(m_tag[i]));
    if (m_rv[i]) begin
      chk("res_data", i, 32'(o_rd(i)), 32'(m_rd[i]));
      chk("res_par", i, 32'(o_par(i)), 32'(m_par[i]));
    end
  endtask

  // One clock: wait to the falling edge, update the model, compare both DUTs.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      model_edge(i);
      if (m_init[i]) compare(i);
    end
  endtask

  task automatic do_reset(int i);
    tb_rst[i] = 1'b1;
    tb_iv[i]  = 1'b0;
    step();
    chk("rst_kx_zero", i, 32'(kx[i]), 32'h0);
    chk("rst_in_ready_low", i, 32'(o_ir(i)), 32'h0);
    step();
    tb_rst[i] = 1'b0;
    step();
  endtask

  // Present a byte until accepted; returns at the falling edge after the handshake.
  task automatic send(int i, logic [7:0] d);
    int n;
    n = 0;
    tb_iv[i] = 1'b1;
    tb_id[i] = d;
    while (!o_ir(i)) begin
      step();
      n++;
      if (n > 64) begin
        chk("send_timeout", i, 32'(n), 32'h0);
        tb_iv[i] = 1'b0;
        return;
      end
    end
    step();
    tb_iv[i] = 1'b0;
  endtask

  task automatic wait_res(int i, output logic [7:0] d, output logic [TAG_W-1:0] t,
                          output logic p);
    int n;
    n = 0;
    while (!o_rv(i)) begin
      step();
      n++;
      if (n > 64) begin
        chk("result_timeout", i, 32'(n), 32'h0);
        break;
      end
    end
    d = o_rd(i);
    t = o_tag(i);
    p = o_par(i);
  endtask

  task automatic consume(int i, int hold);
    tb_rr[i] = 1'b0;
    repeat (hold) step();
    tb_rr[i] = 1'b1;
    step();
    tb_rr[i] = 1'b0;
  endtask

  initial begin
    logic [7:0]       d;
    logic [TAG_W-1:0] t;
    logic             p;
    logic [7:0]       a;
    logic [7:0]       b;
    int               cb;
    int               i;

    for (int k = 0; k < 2; k++) begin
      tb_rst[k] = 1'b1; tb_iv[k] = 1'b0; tb_rr[k] = 1'b0; tb_id[k] = '0;
      m_init[k] = 1'b0; m_nb[k] = 0; m_age[k] = 0; m_kx[k] = '0; m_rv[k] = 1'b0;
      m_rd[k] = '0; m_tag[k] = '0; m_par[k] = 1'b0;
    end
    do_reset(0);
    do_reset(1);

    // Basic transaction, result one edge after B.
    tb_rr[0] = 1'b1;
    send(0, 8'h3C);
    send(0, 8'h0F);
    cb = cyc;
    wait_res(0, d, t, p);
    chk("t1_latency", 0, 32'(cyc - cb), 32'd1);
    chk("t1_data", 0, 32'(d), 32'h33);
    chk("t1_tag", 0, 32'(t), 32'h0);
    chk("t1_par", 0, 32'(p), 32'h0);
    step();
    tb_rr[0] = 1'b0;

    // Result held while res_ready stays low.
    send(0, 8'h3C);
    send(0, 8'h0F);
    wait_res(0, d, t, p);
    chk("t2_tag", 0, 32'(t), 32'h1);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t2_hold_valid", 0, 32'(o_rv(0)), 32'h1);
      chk("t2_hold_data", 0, 32'(o_rd(0)), 32'h33);
      chk("t2_hold_kx", 0, 32'(kx[0]), 32'h0F3C);
      chk("t2_hold_in_ready", 0, 32'(o_ir(0)), 32'h0);
    end
    consume(0, 0);

    // 17 back-to-back transactions: tags wrap after 15.
    do_reset(0);
    tb_rr[0] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      send(0, a);
      send(0, b);
      wait_res(0, d, t, p);
      chk("t3_tag", 0, 32'(t), 32'(k % 16));
      chk("t3_data", 0, 32'(d), 32'(a ^ b));
      step();
    end
    tb_rr[0] = 1'b0;

    // Reset while waiting for B discards the A byte.
    send(0, 8'hAA);
    do_reset(0);
    send(0, 8'h01);
    send(0, 8'h02);
    wait_res(0, d, t, p);
    chk("t4_data", 0, 32'(d), 32'h03);
    chk("t4_tag", 0, 32'(t), 32'h0);
    consume(0, 1);

    // Gap of five cycles between A and B.
    send(0, 8'h5A);
    repeat (5) step();
    chk("t5_wait_in_ready", 0, 32'(o_ir(0)), 32'h1);
    chk("t5_wait_kx_lo", 0, 32'(kx[0][7:0]), 32'h5A);
    send(0, 8'hC3);
    wait_res(0, d, t, p);
    chk("t5_data", 0, 32'(d), 32'h99);
    consume(0, 2);

    // Long evaluation window on the EVAL_CYCLES=15 instance.
    send(1, 8'hFF);
    send(1, 8'h01);
    cb = cyc;
    wait_res(1, d, t, p);
    chk("t6_latency", 1, 32'(cyc - cb), 32'd15);
    chk("t6_data", 1, 32'(d), 32'hFE);
    chk("t6_par", 1, 32'(p), 32'(PAR_EN));
    consume(1, 0);

    // Randomized traffic on both instances with occasional resets.
    for (int r = 0; r < 40; r++) begin
      i = r % 2;
      a = 8'($urandom);
      b = 8'($urandom);
      repeat ($urandom_range(0, 2)) step();
      send(i, a);
      if ($urandom_range(0, 9) == 0) begin
        do_reset(i);
        continue;
      end
      repeat ($urandom_range(0, 3)) step();
      send(i, b);
      wait_res(i, d, t, p);
      chk("rand_data", i, 32'(d), 32'(a ^ b));
      consume(i, $urandom_range(0, 3));
    end

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hd_kernel_driver.md
# hd_kernel_driver

Sequential initiator for the 16-in/8-out combinational Hacker's-Delight FHE kernels (hd01..hdNN): accepts operand bytes over a valid/ready stream, pairs them into one 16-bit kernel input word, holds it stable on the kernel inputs for a programmable evaluation window, captures the 8-bit kernel result, and returns it with a wrapping tag over a valid/ready result stream. Sits between the benchmark harness byte stream and any `top`-style kernel instance; the kernel itself is instantiated outside this block.

## Interface
- `EVAL_CYCLES`, 1, cycles kx_o is held before ky_i is sampled; legal 1..15; 0 is a compile-time error.
- `TAG_W`, 4, result tag width; tag wraps modulo 2^TAG_W.

- `clk`  in  1  sole clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand byte present.
- `in_ready`  out  1  block accepts operand byte.
- `in_data`  in  8  operand byte; first accepted = A, second = B.
- `kx_o`  out  16  kernel inputs: kx_o[7:0]=A drives x0..x7, kx_o[15:8]=B drives x8..x15.
- `ky_i`  in  8  kernel outputs y0..y7 as ky_i[0..7].
- `res_valid`  out  1  result held.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  8  captured ky_i.
- `res_tag`  out  TAG_W  sequence number of this result.
- `res_par`  out  1  parity of res_data (see Configuration).

## Operation
- States: IDLE, WAIT_B, EVAL, OUT.
- IDLE: in_ready=1; on in_valid&in_ready store in_data in kx_o[7:0] -> WAIT_B.
- WAIT_B: in_ready=1; on handshake store in_data in kx_o[15:8], cnt<=EVAL_CYCLES-1 -> EVAL.
- EVAL: in_ready=0; if cnt==0: res_data<=ky_i, res_valid<=1 -> OUT; else cnt<=cnt-1.
- OUT: in_ready=0; res_valid=1, res_data/res_tag/res_par stable; on res_valid&res_ready: res_valid<=0, res_tag<=res_tag+1 (wraps 2^TAG_W-1 -> 0) -> IDLE.
- kx_o changes only on input handshakes; holds through EVAL and OUT, and after OUT until next A byte (A byte updates low half only).
- in_ready is a combinational function of state, forced 0 while rst=1.
- No overlap: next A is not accepted in the cycle the result is consumed.
- Reset mid-operation: any state -> IDLE on the edge with rst=1; in-flight A/B bytes and pending result discarded.

## Timing
- Reset values: in_ready=0 (during rst), kx_o=0, res_valid=0, res_data=0, res_tag=0, res_par=0, cnt=0, state IDLE.
- B accepted at edge k -> ky_i sampled at edge k+EVAL_CYCLES -> res_valid=1 from that edge.
- Minimum period per result: 3+EVAL_CYCLES cycles (A, B, EVAL_CYCLES, 1 OUT cycle with res_ready=1).
- in_valid may drop between A and B; WAIT_B holds indefinitely.
- res_ready held low: OUT holds indefinitely, no data change.

## Configuration
- `HD_DRV_PARITY_EN` defined: res_par<=^ky_i captured on the same edge as res_data.
- Undefined: res_par tied 0, no parity logic; port remains present.

## Structure
- Package `hd_drv_pkg`: state enum (IDLE, WAIT_B, EVAL, OUT), constants KX_W=16, KY_W=8, CNT_W=4.
- Sub-module `hd_drv_eval_timer`: loadable 4-bit down-counter with zero flag; driver FSM loads it in WAIT_B and polls zero in EVAL.

## Test plan
Bench kernel stub ky_i = kx_o[7:0] ^ kx_o[15:8].
- Reset then A=0x3C, B=0x0F, res_ready=1, EVAL_CYCLES=1 -> res_valid one edge after B, res_data=0x33, res_tag=0, res_par=0 (parity build).
- res_ready low 10 cycles after result -> res_valid, res_data, kx_o=0x0F3C stable; in_ready=0 throughout.
- 17 back-to-back transactions, TAG_W=4 -> tags 0..15 then 0.
- EVAL_CYCLES=15, A=0xFF, B=0x01 -> res_valid exactly 15 edges after B; res_data=0xFE, res_par=1 with HD_DRV_PARITY_EN, 0 without.
- rst pulsed in WAIT_B after A=0xAA, then A=0x01, B=0x02 -> kx_o=0 after reset, result 0x03, tag 0.
- in_valid gap of 5 cycles between A and B -> block waits in WAIT_B; result correct.
